// File: rtl/ad2s1210_emulator.sv
// Emulates the SPI side of an AD2S1210 resolver-to-digital converter.
//
// Normal mode (mode=0): each frame shifts out 24 bits, {position, fault}, MSB first.
// Configuration mode (mode=1): each frame is 8 bits. A received byte with bit7 set selects an
// address. A byte with bit7 clear writes that address if it is a config register. Every config
// frame shifts out the value at the address held when the frame started. Reading address 0xFF
// returns the sticky fault register and arms it to reload on the next SAMPLE fall.
//
// Ports:
//   clock        system clock, all logic on posedge
//   reset        synchronous, active-high
//   sample       active-low SAMPLE strobe; its fall latches position and handles fault reload
//   mode         0 = position readout, 1 = configuration; sampled at the ss_n fall
//   sclk         SPI clock, idle low; miso shifts on rise, mosi is captured on fall
//   ss_n         SPI slave select, active low
//   mosi         SPI data in
//   miso         SPI data out, 0 whenever no frame is shifting
//   position_in  emulated angle
//   fault_in     emulated fault levels, OR-ed into the sticky fault register
//   fault_read   one-cycle pulse when a read frame of address 0xFF commits
//   cfg_regs     config register file, entry 0 in the LSBs
module ad2s1210_emulator #(
  parameter int SYNC_STAGES = 2,
  parameter int N_CFG_REGS  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sample,
  input  logic                    mode,
  input  logic                    sclk,
  input  logic                    ss_n,
  input  logic                    mosi,
  output logic                    miso,
  input  logic [15:0]             position_in,
  input  logic [7:0]              fault_in,
  output logic                    fault_read,
  output logic [8*N_CFG_REGS-1:0] cfg_regs
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} state_e;

  localparam logic [7:0] CfgBase  = 8'h88;
  localparam logic [7:0] FaultAdr = 8'hFF;
  localparam logic [8:0] CfgEnd   = 9'(136 + N_CFG_REGS);
  // Packed as {sample, ss_n, mosi, sclk}; idle levels for the two strobes are high.
  localparam logic [3:0] SyncRst  = 4'b1100;

  // ---------------------------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // ---------------------------------------------------------------------------------------------
  logic [3:0] sync_q [SYNC_STAGES];
  logic       sclk_s, ss_n_s, mosi_s, sample_s;
  logic       sclk_prev, ss_n_prev, sample_prev;
  logic       sclk_rise, sclk_fall, ss_fall, sample_fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SyncRst;
      sclk_prev   <= 1'b0;
      ss_n_prev   <= 1'b1;
      sample_prev <= 1'b1;
    end else begin
      sync_q[0] <= {sample, ss_n, mosi, sclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_prev   <= sclk_s;
      ss_n_prev   <= ss_n_s;
      sample_prev <= sample_s;
    end
  end

  assign sclk_s      = sync_q[SYNC_STAGES-1][0];
  assign mosi_s      = sync_q[SYNC_STAGES-1][1];
  assign ss_n_s      = sync_q[SYNC_STAGES-1][2];
  assign sample_s    = sync_q[SYNC_STAGES-1][3];

  assign sclk_rise   = sclk_s & ~sclk_prev;
  assign sclk_fall   = ~sclk_s & sclk_prev;
  assign ss_fall     = ss_n_prev & ~ss_n_s;
  assign sample_fall = sample_prev & ~sample_s;

  // ---------------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic        frame_mode;
  logic [23:0] tx_shift;
  logic [7:0]  rx_shift;
  logic [4:0]  bit_cnt;
  logic [7:0]  addr_reg;
  logic [15:0] pos_reg;
  logic [7:0]  fault_reg;
  logic        fault_read_flag;
  logic [7:0]  cfg_q [N_CFG_REGS];

  logic [7:0]  addr_off;
  logic        addr_in_cfg;
  logic [7:0]  rd_val;
  logic [4:0]  last_bit;

  assign addr_off    = addr_reg - CfgBase;
  assign addr_in_cfg = (addr_reg != FaultAdr) && (addr_reg >= CfgBase) &&
                       ({1'b0, addr_reg} < CfgEnd);
  assign last_bit    = frame_mode ? 5'd7 : 5'd23;

  // Read value for the address currently selected.
  always_comb begin
    rd_val = 8'h00;
    if (addr_reg == FaultAdr) begin
      rd_val = fault_reg;
    end else if (addr_in_cfg) begin
      for (int i = 0; i < N_CFG_REGS; i++) begin
        if (addr_off == 8'(i)) rd_val = cfg_q[i];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ss_fall) state_d = StLoad;
      StLoad:   state_d = StShift;
      StShift: begin
        // A completing sclk fall wins over a simultaneous ss_n release.
        if (sclk_fall && (bit_cnt == last_bit)) state_d = StCommit;
        else if (ss_n_s)                        state_d = StIdle;
      end
      StCommit: state_d = ss_n_s ? StIdle : StLoad;
      default:  state_d = StIdle;
    endcase
  end

  assign miso       = (state_q == StShift) ? tx_shift[23] : 1'b0;
  // addr_reg can only change in COMMIT, so here it still names the address this frame read.
  assign fault_read = (state_q == StCommit) && frame_mode && (addr_reg == FaultAdr);

  // ---------------------------------------------------------------------------------------------
  // Shift datapath, address and config register file
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_mode <= 1'b0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      addr_reg   <= 8'h00;
      for (int i = 0; i < N_CFG_REGS; i++) cfg_q[i] <= 8'h00;
    end else begin
      if ((state_q == StIdle) && ss_fall) frame_mode <= mode;

      unique case (state_q)
        StLoad: begin
          tx_shift <= frame_mode ? {rd_val, 16'h0000} : {pos_reg, fault_reg};
          rx_shift <= '0;
          bit_cnt  <= '0;
        end
        StShift: begin
          if (sclk_rise) tx_shift <= {tx_shift[22:0], 1'b0};
          if (sclk_fall) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 5'd1;
          end
        end
        StCommit: begin
          if (frame_mode) begin
            if (rx_shift[7]) begin
              addr_reg <= rx_shift;
            end else if (addr_in_cfg) begin
              for (int i = 0; i < N_CFG_REGS; i++) begin
                if (addr_off == 8'(i)) cfg_q[i] <= {1'b0, rx_shift[6:0]};
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cfg_regs = '0;
    for (int i = 0; i < N_CFG_REGS; i++) cfg_regs[8*i +: 8] = cfg_q[i];
  end

  // ---------------------------------------------------------------------------------------------
  // Position latch and sticky fault register
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      pos_reg         <= '0;
      fault_reg       <= '0;
      fault_read_flag <= 1'b0;
    end else begin
      if (sample_fall) pos_reg <= position_in;

      // The flag tested here is the one from before this cycle, so a fault read committing in
      // the same cycle as a SAMPLE fall only arms the reload for the following fall.
      if (sample_fall && fault_read_flag) fault_reg <= fault_in;
      else                                fault_reg <= fault_reg | fault_in;

      if (fault_read)                          fault_read_flag <= 1'b1;
      else if (sample_fall && fault_read_flag) fault_read_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad2s1210_emulator.sv
// Directed bench for ad2s1210_emulator: SPI frames are bit-banged at clock/16, miso is
// sampled just before each sclk rise and mosi is changed together with that rise.
module tb_ad2s1210_emulator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample = 1'b1;
  logic        mode = 1'b0;
  logic        sclk = 1'b0;
  logic        ss_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] position_in = '0;
  logic [7:0]  fault_in = '0;
  logic        fault_read;
  logic [63:0] cfg_regs;

  int checks = 0;
  int failures = 0;
  int fr_count = 0;

  ad2s1210_emulator #(
    .SYNC_STAGES(2),
    .N_CFG_REGS (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .sample     (sample),
    .mode       (mode),
    .sclk       (sclk),
    .ss_n       (ss_n),
    .mosi       (mosi),
    .miso       (miso),
    .position_in(position_in),
    .fault_in   (fault_in),
    .fault_read (fault_read),
    .cfg_regs   (cfg_regs)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (fault_read === 1'b1) fr_count++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Runs one frame of nbits; stops early (ss_n released) after stop_after bits.
  task automatic spi_frame(input int nbits, input logic [23:0] mo, input logic m,
                           input int stop_after, output logic [23:0] rx);
    rx = '0;
    mode = m;
    ss_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits && i < stop_after; i++) begin
      rx = {rx[22:0], miso};
      mosi = mo[nbits-1-i];
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
      wait_clk(8);
    end
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic cfg_frame(input logic [7:0] b, output logic [7:0] rd);
    logic [23:0] rx;
    spi_frame(8, {16'h0000, b}, 1'b1, 99, rx);
    rd = rx[7:0];
  endtask

  task automatic normal_read(output logic [23:0] rx);
    spi_frame(24, 24'h000000, 1'b0, 99, rx);
  endtask

  task automatic sample_pulse();
    sample = 1'b0;
    wait_clk(4);
    sample = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_reset();
    logic [23:0] rx;
    reset = 1'b1;
    wait_clk(3);
    checks++;
    if (miso !== 1'b0) begin
      failures++; $display("FAIL reset_miso got=%b exp=0", miso);
    end
    checks++;
    if (fault_read !== 1'b0) begin
      failures++; $display("FAIL reset_fault_read got=%b exp=0", fault_read);
    end
    checks++;
    if (cfg_regs !== 64'h0) begin
      failures++; $display("FAIL reset_cfg got=%h exp=0", cfg_regs);
    end
    reset = 1'b0;
    wait_clk(4);
    normal_read(rx);
    checks++;
    if (rx !== 24'h000000) begin
      failures++; $display("FAIL reset_read got=%h exp=000000", rx);
    end
  endtask

  task automatic test_position();
    logic [23:0] rx;
    position_in = 16'h1234;
    fault_in = 8'h00;
    sample_pulse();
    normal_read(rx);
    checks++;
    if (rx !== 24'h123400) begin
      failures++; $display("FAIL pos_1234 got=%h exp=123400", rx);
    end
    position_in = 16'hBEEF;
    sample_pulse();
    position_in = 16'h1234; // changed after the latch: must not show up
    normal_read(rx);
    checks++;
    if (rx !== 24'hBEEF00) begin
      failures++; $display("FAIL pos_beef got=%h exp=beef00", rx);
    end
  endtask

  task automatic test_fault_sticky();
    logic [23:0] rx;
    position_in = 16'h1234;
    fault_in = 8'h40;
    wait_clk(1);
    fault_in = 8'h00;
    sample_pulse();
    normal_read(rx);
    checks++;
    if (rx !== 24'h123440) begin
      failures++; $display("FAIL fault_sticky got=%h exp=123440", rx);
    end
    sample_pulse();
    normal_read(rx);
    checks++;
    if (rx !== 24'h123440) begin
      failures++; $display("FAIL fault_sticky_2 got=%h exp=123440", rx);
    end
  endtask

  task automatic test_config();
    logic [7:0] rd;
    cfg_frame(8'h8A, rd);
    cfg_frame(8'h5C, rd);
    checks++;
    if (cfg_regs !== 64'h0000_0000_005C_0000) begin
      failures++; $display("FAIL cfg_write got=%h exp=00000000005c0000", cfg_regs);
    end
    cfg_frame(8'h8A, rd);
    cfg_frame(8'h00, rd);
    checks++;
    if (rd !== 8'h5C) begin
      failures++; $display("FAIL cfg_read got=%h exp=5c", rd);
    end
    // The dummy byte is itself a data write of 0x00 to the selected register.
    checks++;
    if (cfg_regs !== 64'h0) begin
      failures++; $display("FAIL cfg_dummy_write got=%h exp=0", cfg_regs);
    end
    cfg_frame(8'h8F, rd);
    cfg_frame(8'h7F, rd);
    checks++;
    if (cfg_regs !== 64'h7F00_0000_0000_0000) begin
      failures++; $display("FAIL cfg_top_entry got=%h exp=7f00000000000000", cfg_regs);
    end
    cfg_frame(8'h90, rd);
    cfg_frame(8'h12, rd);
    cfg_frame(8'h00, rd);
    checks++;
    if (rd !== 8'h00) begin
      failures++; $display("FAIL cfg_out_of_range_read got=%h exp=00", rd);
    end
    checks++;
    if (cfg_regs !== 64'h7F00_0000_0000_0000) begin
      failures++; $display("FAIL cfg_out_of_range_write got=%h exp=7f00000000000000", cfg_regs);
    end
  endtask

  task automatic test_fault_read();
    logic [7:0]  rd;
    logic [23:0] rx;
    fr_count = 0;
    cfg_frame(8'hFF, rd);
    cfg_frame(8'h00, rd);
    checks++;
    if (rd !== 8'h40) begin
      failures++; $display("FAIL fault_read_value got=%h exp=40", rd);
    end
    checks++;
    if (fr_count !== 1) begin
      failures++; $display("FAIL fault_read_pulses got=%0d exp=1", fr_count);
    end
    position_in = 16'h5678;
    fault_in = 8'h00;
    sample_pulse();
    normal_read(rx);
    checks++;
    if (rx !== 24'h567800) begin
      failures++; $display("FAIL fault_cleared got=%h exp=567800", rx);
    end
    checks++;
    if (fr_count !== 1) begin
      failures++; $display("FAIL fault_read_normal_frame got=%0d exp=1", fr_count);
    end
  endtask

  task automatic test_abort();
    logic [7:0]  rd;
    logic [23:0] rx;
    cfg_frame(8'h88, rd);
    fr_count = 0;
    spi_frame(8, 24'h000033, 1'b1, 5, rx);
    checks++;
    if (cfg_regs !== 64'h7F00_0000_0000_0000) begin
      failures++; $display("FAIL abort_no_write got=%h exp=7f00000000000000", cfg_regs);
    end
    checks++;
    if (fr_count !== 0) begin
      failures++; $display("FAIL abort_fault_read got=%0d exp=0", fr_count);
    end
    cfg_frame(8'h33, rd);
    checks++;
    if (cfg_regs !== 64'h7F00_0000_0000_0033) begin
      failures++; $display("FAIL abort_then_write got=%h exp=7f00000000000033", cfg_regs);
    end
  endtask

  task automatic test_reset_mid();
    logic [23:0] rx;
    position_in = 16'h1111;
    sample_pulse();
    mode = 1'b0;
    ss_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 10; i++) begin
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
      wait_clk(8);
    end
    reset = 1'b1;
    wait_clk(2);
    checks++;
    if (miso !== 1'b0) begin
      failures++; $display("FAIL reset_mid_miso got=%b exp=0", miso);
    end
    checks++;
    if (cfg_regs !== 64'h0) begin
      failures++; $display("FAIL reset_mid_cfg got=%h exp=0", cfg_regs);
    end
    ss_n = 1'b1;
    reset = 1'b0;
    wait_clk(8);
    checks++;
    if (miso !== 1'b0) begin
      failures++; $display("FAIL reset_mid_idle_miso got=%b exp=0", miso);
    end
    normal_read(rx);
    checks++;
    if (rx !== 24'h000000) begin
      failures++; $display("FAIL reset_mid_regs got=%h exp=000000", rx);
    end
    position_in = 16'hA5A5;
    sample_pulse();
    normal_read(rx);
    checks++;
    if (rx !== 24'hA5A500) begin
      failures++; $display("FAIL reset_mid_next_frame got=%h exp=a5a500", rx);
    end
  endtask

  initial begin
    test_reset();
    test_position();
    test_fault_sticky();
    test_config();
    test_fault_read();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad2s1210_emulator.md
AD2S1210_EMULATOR -- requirements
Module: ad2s1210_emulator

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on sclk, ss_n, mosi and sample.
REQ-002 SHALL have parameter N_CFG_REGS, default 8, meaning the number of config registers, addressed 0x88 upward.
REQ-003 clock  input  1  system clock; all logic on posedge.
REQ-004 reset  input  1  reset; one clock, synchronous and active-high.
REQ-005 sample  input  1  active-low SAMPLE from the initiator.
REQ-006 mode  input  1  0 = normal position readout, 1 = configuration.
REQ-007 sclk  input  1  SPI clock; idle low.
REQ-008 ss_n  input  1  SPI slave select; active low.
REQ-009 mosi  input  1  SPI data from the initiator.
REQ-010 miso  output  1  SPI data to the initiator.
REQ-011 position_in  input  16  emulated angle.
REQ-012 fault_in  input  8  emulated fault conditions; per-bit level.
REQ-013 fault_read  output  1  one-cycle pulse on completion of a fault register read frame.
REQ-014 cfg_regs  output  8*N_CFG_REGS  register file contents; entry 0 in the LSBs.

Function
REQ-015 SHALL pass sclk, ss_n, mosi and sample through SYNC_STAGES flops, then detect edges on the synchronized versions.
REQ-016 SHALL support sclk frequencies up to clock/8.
- sample fall: latch position_in into pos_reg.
- sample fall with fault_read_flag set: load fault_reg <= fault_in and clear the flag.
- Otherwise every cycle: fault_reg <= fault_reg | fault_in (sticky).
REQ-017 SHALL sample the mode input at the ss_n fall into frame_mode; mode changes while ss_n is low have no effect until the next ss_n fall.
REQ-018 SHALL use a FSM with states IDLE, LOAD, SHIFT, COMMIT.
- IDLE -> LOAD on the synchronized ss_n fall.
- LOAD (one cycle): load tx_shift and set bit_cnt to 0.
  - frame_mode=0: tx_shift = {pos_reg, fault_reg}, 24 bits.
  - frame_mode=1: tx_shift = the 8-bit read value of addr_reg, left-aligned.
- LOAD -> SHIFT.
REQ-019 In SHIFT:
- miso = MSB of tx_shift.
- sclk rise: shift tx_shift left by one.
- sclk fall: shift mosi into rx_shift and increment bit_cnt.
- bit_cnt reaches the frame length (24 normal, 8 config) -> COMMIT.
REQ-020 COMMIT (one cycle), frame_mode=1 only:
- rx_shift[7]=1: addr_reg <= rx_shift.
- rx_shift[7]=0 and addr_reg in 0x88..0x88+N_CFG_REGS-1: write rx_shift[6:0] to that register, bit7 = 0.
- Address outside the range, or addr_reg = 0xFF: write dropped.
- Frame that read addr_reg=0xFF: pulse fault_read and set fault_read_flag.
REQ-021 COMMIT -> IDLE when ss_n is high; otherwise -> LOAD to start a back-to-back frame.
REQ-022 Normal-mode frames commit nothing; mosi is ignored.
REQ-023 Read values by address:
- 0xFF: fault_reg.
- Config range: the stored register.
- Any other address: 0x00.
REQ-024 ss_n rise while in SHIFT before the frame length: abort to IDLE, discard the partial frame, no write, no fault_read, no flag change.
REQ-025 Extra sclk edges after the frame length within one ss_n low: ignored until COMMIT returns to LOAD.
REQ-026 miso SHALL be 0 whenever the state is not SHIFT.
REQ-027 Latency: first miso bit valid no later than SYNC_STAGES+2 clocks after the ss_n fall at the pin.
REQ-028 Simultaneous sample fall and COMMIT of a fault read: the flag is set in COMMIT and fault_reg is not cleared in that cycle; it clears on the next sample fall.

Reset
REQ-029 While reset=1, the following SHALL hold, taking effect on the next clock:
- state = IDLE.
- miso = 0, fault_read = 0.
- pos_reg = 0, fault_reg = 0, fault_read_flag = 0.
- addr_reg = 0x00, all cfg_regs = 0x00.
- Synchronizers: sclk, mosi = 0; ss_n, sample = 1.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no register write; after deassertion the block waits for a fresh ss_n fall.

Verification
REQ-031 position_in=0x1234, fault_in=0; sample pulse; 24-bit normal read -> miso bits 0x123400.
REQ-032 fault_in=0x40 for 1 cycle then 0; sample; normal read -> low byte 0x40; another sample without a fault read -> still 0x40.
REQ-033 Config frames 0x8A, 0x5C -> cfg_regs entry 2 = 0x5C; frames 0x8A, dummy 0x00 -> read returns 0x5C.
REQ-034 Config frame 0xFF, then a read frame -> miso 0x40, fault_read pulses once; next sample with fault_in=0 -> fault_reg = 0x00.
REQ-035 ss_n raised after 5 bits of a data frame 0x33 at addr_reg 0x88 -> entry 0 unchanged, no fault_read.
REQ-036 reset pulsed mid 24-bit frame -> miso=0, all registers 0, next frame correct.
